// File: rtl/control_unit_pkg.sv
// Shared encodings for the RV64 multi-cycle control unit: opcodes, FSM states,
// datapath select codes and the bundle of control outputs.
package control_unit_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RF_ALU = 2'b00;
    localparam logic [1:0] RF_DM  = 2'b01;
    localparam logic [1:0] RF_PC  = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    typedef struct packed {
        logic       load_ir;
        logic       load_pc;
        logic       we_rf;
        logic       we_dm;
        logic       sel_alu_a;
        logic       sel_alu_b;
        logic       sel_pc_a;
        logic       sel_pc_b;
        logic       sel_pc_rf;
        logic [2:0] sel_imme;
        logic [1:0] sel_rf_in;
        logic [1:0] alu_op;
        logic       halt;
    } ctrl_t;

    // Opcodes outside the executable set, LUI included, decode as illegal.
    function automatic logic opcode_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_AUIPC: ok = 1'b1;
            OP_LUI:                    ok = 1'b0;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic ctrl_t with_pc_plus4(input ctrl_t c);
        ctrl_t r;
        r          = c;
        r.load_pc  = 1'b1;
        r.sel_pc_a = 1'b1;
        r.sel_pc_b = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR fields and flags in, enables and selects out.
interface control_unit_if;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7_b5;
    logic       flag_beq;
    logic       flag_bne;
    logic       flag_blt;
    logic       flag_bge;
    logic       flag_bltu;
    logic       flag_bgeu;
    logic       dm_ready;

    logic       load_IR;
    logic       load_PC;
    logic       we_RF;
    logic       we_DM;
    logic       sel_ALU_A;
    logic       sel_ALU_B;
    logic       sel_PC_A;
    logic       sel_PC_B;
    logic       sel_PC_RF;
    logic [2:0] sel_imme;
    logic [1:0] sel_RF_in;
    logic [1:0] alu_op;
    logic       halt;

    modport master (
        input  opcode, func3, func7_b5,
               flag_beq, flag_bne, flag_blt, flag_bge, flag_bltu, flag_bgeu,
               dm_ready,
        output load_IR, load_PC, we_RF, we_DM,
               sel_ALU_A, sel_ALU_B, sel_PC_A, sel_PC_B, sel_PC_RF,
               sel_imme, sel_RF_in, alu_op, halt
    );

    modport slave (
        output opcode, func3, func7_b5,
               flag_beq, flag_bne, flag_blt, flag_bge, flag_bltu, flag_bgeu,
               dm_ready,
        input  load_IR, load_PC, we_RF, we_DM,
               sel_ALU_A, sel_ALU_B, sel_PC_A, sel_PC_B, sel_PC_RF,
               sel_imme, sel_RF_in, alu_op, halt
    );

endinterface

// File: rtl/control_unit_branch_resolve.sv
// Branch condition resolution: picks the ALU compare flag named by func3 and
// flags the two func3 codes that have no branch meaning.
module branch_resolve (
    input  logic [2:0] func3_i,
    input  logic       flag_beq_i,
    input  logic       flag_bne_i,
    input  logic       flag_blt_i,
    input  logic       flag_bge_i,
    input  logic       flag_bltu_i,
    input  logic       flag_bgeu_i,
    output logic       taken_o,
    output logic       br_illegal_o
);

    always_comb begin
        taken_o      = 1'b0;
        br_illegal_o = 1'b0;
        case (func3_i)
            3'b000:  taken_o = flag_beq_i;
            3'b001:  taken_o = flag_bne_i;
            3'b100:  taken_o = flag_blt_i;
            3'b101:  taken_o = flag_bge_i;
            3'b110:  taken_o = flag_bltu_i;
            3'b111:  taken_o = flag_bgeu_i;
            default: br_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle RV64 control FSM: FETCH -> DECODE -> EXEC [-> MEM [-> WB]],
// with outputs decoded combinationally from state, opcode and branch outcome.
module control_unit
    import control_unit_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    control_unit_if.master bus
);

    state_e state_q, state_d;
    ctrl_t  ctrl;
    logic   taken;
    logic   br_illegal;
    logic   illegal;
    logic   is_store;

    branch_resolve u_branch_resolve (
        .func3_i      (bus.func3),
        .flag_beq_i   (bus.flag_beq),
        .flag_bne_i   (bus.flag_bne),
        .flag_blt_i   (bus.flag_blt),
        .flag_bge_i   (bus.flag_bge),
        .flag_bltu_i  (bus.flag_bltu),
        .flag_bgeu_i  (bus.flag_bgeu),
        .taken_o      (taken),
        .br_illegal_o (br_illegal)
    );

    assign illegal  = !opcode_supported(bus.opcode) ||
                      ((bus.opcode == OP_BRANCH) && br_illegal);
    assign is_store = (bus.opcode == OP_STORE);

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RST:    state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = illegal ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
                if ((bus.opcode == OP_LOAD) || is_store) state_d = ST_MEM;
                else                                     state_d = ST_FETCH;
            end
            ST_MEM: begin
                if (bus.dm_ready) state_d = is_store ? ST_FETCH : ST_WB;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_TRAP;
        endcase
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        ctrl = '0;
        unique case (state_q)
            ST_FETCH: ctrl.load_ir = 1'b1;
            ST_EXEC: begin
                case (bus.opcode)
                    OP_R: begin
                        ctrl.sel_alu_a = 1'b1;
                        ctrl.sel_alu_b = 1'b1;
                        ctrl.alu_op    = {1'b0, bus.func7_b5};
                        ctrl.we_rf     = 1'b1;
                        ctrl.sel_rf_in = RF_ALU;
                        ctrl           = with_pc_plus4(ctrl);
                    end
                    OP_I: begin
                        ctrl.sel_alu_a = 1'b1;
                        ctrl.sel_imme  = IMM_I;
                        ctrl.alu_op    = ALU_ADD;
                        ctrl.we_rf     = 1'b1;
                        ctrl           = with_pc_plus4(ctrl);
                    end
                    OP_LOAD: begin
                        ctrl.sel_alu_a = 1'b1;
                        ctrl.sel_imme  = IMM_I;
                    end
                    OP_STORE: begin
                        ctrl.sel_alu_a = 1'b1;
                        ctrl.sel_imme  = IMM_S;
                    end
                    OP_BRANCH: begin
                        ctrl.sel_alu_a = 1'b1;
                        ctrl.sel_alu_b = 1'b1;
                        ctrl.alu_op    = ALU_SUB;
                        ctrl.sel_imme  = IMM_B;
                        ctrl.load_pc   = 1'b1;
                        ctrl.sel_pc_a  = 1'b1;
                        ctrl.sel_pc_b  = !taken;
                    end
                    OP_JAL: begin
                        ctrl.sel_imme  = IMM_J;
                        ctrl.we_rf     = 1'b1;
                        ctrl.sel_rf_in = RF_PC;
                        ctrl.sel_pc_rf = 1'b1;
                        ctrl.load_pc   = 1'b1;
                        ctrl.sel_pc_a  = 1'b1;
                    end
                    // rs1 is read before the edge, so rd==rs1 still jumps to the old rs1+imm.
                    OP_JALR: begin
                        ctrl.sel_imme  = IMM_I;
                        ctrl.we_rf     = 1'b1;
                        ctrl.sel_rf_in = RF_PC;
                        ctrl.sel_pc_rf = 1'b1;
                        ctrl.load_pc   = 1'b1;
                    end
                    OP_AUIPC: begin
                        ctrl.sel_imme  = IMM_U;
                        ctrl.we_rf     = 1'b1;
                        ctrl.sel_rf_in = RF_PC;
                        ctrl           = with_pc_plus4(ctrl);
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                ctrl.sel_alu_a = 1'b1;
                if (is_store) begin
                    ctrl.sel_imme = IMM_S;
                    ctrl.we_dm    = 1'b1;
                    if (bus.dm_ready) ctrl = with_pc_plus4(ctrl);
                end else begin
                    ctrl.sel_imme = IMM_I;
                end
            end
            ST_WB: begin
                ctrl.sel_imme  = IMM_I;
                ctrl.sel_rf_in = RF_DM;
                ctrl.we_rf     = 1'b1;
                ctrl           = with_pc_plus4(ctrl);
            end
            ST_TRAP: ctrl.halt = 1'b1;
            default: ;
        endcase
    end

    assign bus.load_IR   = ctrl.load_ir;
    assign bus.load_PC   = ctrl.load_pc;
    assign bus.we_RF     = ctrl.we_rf;
    assign bus.we_DM     = ctrl.we_dm;
    assign bus.sel_ALU_A = ctrl.sel_alu_a;
    assign bus.sel_ALU_B = ctrl.sel_alu_b;
    assign bus.sel_PC_A  = ctrl.sel_pc_a;
    assign bus.sel_PC_B  = ctrl.sel_pc_b;
    assign bus.sel_PC_RF = ctrl.sel_pc_rf;
    assign bus.sel_imme  = ctrl.sel_imme;
    assign bus.sel_RF_in = ctrl.sel_rf_in;
    assign bus.alu_op    = ctrl.alu_op;
    assign bus.halt      = ctrl.halt;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle output vectors checked against
// hand-written expectations for every instruction class, stalls, traps and resets.
module tb_control_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    control_unit_if bus ();

    control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: load_IR load_PC we_RF we_DM ALU_A ALU_B PC_A PC_B PC_RF imme RF_in alu_op halt
    localparam logic [16:0] V_ZERO  = 17'b0_0_0_0_0_0_0_0_0_000_00_00_0;
    localparam logic [16:0] V_FETCH = 17'b1_0_0_0_0_0_0_0_0_000_00_00_0;
    localparam logic [16:0] V_ADD   = 17'b0_1_1_0_1_1_1_1_0_000_00_00_0;
    localparam logic [16:0] V_SUB   = 17'b0_1_1_0_1_1_1_1_0_000_00_01_0;
    localparam logic [16:0] V_ADDI  = 17'b0_1_1_0_1_0_1_1_0_000_00_00_0;
    localparam logic [16:0] V_LD_EX = 17'b0_0_0_0_1_0_0_0_0_000_00_00_0;
    localparam logic [16:0] V_LD_WB = 17'b0_1_1_0_0_0_1_1_0_000_01_00_0;
    localparam logic [16:0] V_SD_EX = 17'b0_0_0_0_1_0_0_0_0_001_00_00_0;
    localparam logic [16:0] V_SD_MW = 17'b0_0_0_1_1_0_0_0_0_001_00_00_0;
    localparam logic [16:0] V_SD_MD = 17'b0_1_0_1_1_0_1_1_0_001_00_00_0;
    localparam logic [16:0] V_BR_T  = 17'b0_1_0_0_1_1_1_0_0_010_00_01_0;
    localparam logic [16:0] V_BR_N  = 17'b0_1_0_0_1_1_1_1_0_010_00_01_0;
    localparam logic [16:0] V_JAL   = 17'b0_1_1_0_0_0_1_0_1_011_11_00_0;
    localparam logic [16:0] V_JALR  = 17'b0_1_1_0_0_0_0_0_1_000_11_00_0;
    localparam logic [16:0] V_AUIPC = 17'b0_1_1_0_0_0_1_1_0_100_11_00_0;
    localparam logic [16:0] V_TRAP  = 17'b0_0_0_0_0_0_0_0_0_000_00_00_1;

    function automatic logic [16:0] outs();
        return {bus.load_IR, bus.load_PC, bus.we_RF, bus.we_DM, bus.sel_ALU_A, bus.sel_ALU_B,
                bus.sel_PC_A, bus.sel_PC_B, bus.sel_PC_RF, bus.sel_imme, bus.sel_RF_in,
                bus.alu_op, bus.halt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.opcode   = op;
        bus.func3    = f3;
        bus.func7_b5 = f7;
    endtask

    // Flag order: beq bne blt bge bltu bgeu
    task automatic set_flags(input logic [5:0] f);
        {bus.flag_beq, bus.flag_bne, bus.flag_blt, bus.flag_bge, bus.flag_bltu, bus.flag_bgeu} = f;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);
        set_flags(6'b111111);
        bus.dm_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (outs() !== V_ZERO)
                begin errors++; $display("FAIL reset_hold cyc%0d: got %b expected %b", i, outs(), V_ZERO); end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs() !== V_ZERO)
            begin errors++; $display("FAIL reset_release_rst: got %b expected %b", outs(), V_ZERO); end
        tick();
        checks++;
        if (outs() !== V_FETCH)
            begin errors++; $display("FAIL reset_first_fetch: got %b expected %b", outs(), V_FETCH); end
        bus.dm_ready = 1'b0;
        set_flags(6'b000000);
    endtask

    task automatic test_alu_ops();
        logic [6:0]  op [3];
        logic        f7 [3];
        logic [16:0] ex [3];
        logic [16:0] seq [3];
        op = '{7'b0110011, 7'b0110011, 7'b0010011};
        f7 = '{1'b0, 1'b1, 1'b1};
        ex = '{V_ADD, V_SUB, V_ADDI};
        for (int k = 0; k < 3; k++) begin
            set_instr(op[k], 3'b000, f7[k]);
            seq = '{V_FETCH, V_ZERO, ex[k]};
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (outs() !== seq[i])
                    begin errors++; $display("FAIL alu_op%0d cyc%0d: got %b expected %b", k, i, outs(), seq[i]); end
                tick();
            end
        end
        checks++;
        if (outs() !== V_FETCH)
            begin errors++; $display("FAIL alu_back_to_back_fetch: got %b expected %b", outs(), V_FETCH); end
    endtask

    task automatic test_load_stall();
        logic [16:0] seq [10];
        logic        rdy [10];
        seq = '{V_FETCH, V_ZERO, V_LD_EX, V_LD_EX, V_LD_EX, V_LD_EX, V_LD_EX, V_LD_EX, V_LD_WB, V_FETCH};
        rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        set_instr(7'b0000011, 3'b011, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.dm_ready = rdy[i];
            #1;
            checks++;
            if (outs() !== seq[i])
                begin errors++; $display("FAIL load cyc%0d: got %b expected %b", i, outs(), seq[i]); end
            if (i < 9) tick();
        end
    endtask

    task automatic test_store_stall();
        logic [16:0] seq [7];
        logic        rdy [7];
        seq = '{V_FETCH, V_ZERO, V_SD_EX, V_SD_MW, V_SD_MW, V_SD_MD, V_FETCH};
        rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        set_instr(7'b0100011, 3'b011, 1'b0);
        for (int i = 0; i < 7; i++) begin
            bus.dm_ready = rdy[i];
            #1;
            checks++;
            if (outs() !== seq[i])
                begin errors++; $display("FAIL store cyc%0d: got %b expected %b", i, outs(), seq[i]); end
            if (i < 6) tick();
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3 [4];
        logic [5:0]  fl [4];
        logic [16:0] ex [4];
        logic [16:0] seq [3];
        f3 = '{3'b001, 3'b001, 3'b111, 3'b100};
        fl = '{6'b010000, 6'b101111, 6'b000001, 6'b110111};
        ex = '{V_BR_T, V_BR_N, V_BR_T, V_BR_N};
        for (int k = 0; k < 4; k++) begin
            set_instr(7'b1100011, f3[k], 1'b0);
            set_flags(fl[k]);
            seq = '{V_FETCH, V_ZERO, ex[k]};
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (outs() !== seq[i])
                    begin errors++; $display("FAIL branch%0d cyc%0d: got %b expected %b", k, i, outs(), seq[i]); end
                tick();
            end
        end
        set_flags(6'b000000);
    endtask

    task automatic test_jumps();
        logic [6:0]  op [3];
        logic [16:0] ex [3];
        logic [16:0] seq [3];
        op = '{7'b1101111, 7'b1100111, 7'b0010111};
        ex = '{V_JAL, V_JALR, V_AUIPC};
        for (int k = 0; k < 3; k++) begin
            set_instr(op[k], 3'b000, 1'b0);
            seq = '{V_FETCH, V_ZERO, ex[k]};
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (outs() !== seq[i])
                    begin errors++; $display("FAIL jump%0d cyc%0d: got %b expected %b", k, i, outs(), seq[i]); end
                tick();
            end
        end
    endtask

    task automatic test_mid_reset();
        set_instr(7'b0110011, 3'b000, 1'b0);
        tick();
        tick();
        checks++;
        if (outs() !== V_ADD)
            begin errors++; $display("FAIL midrst_exec: got %b expected %b", outs(), V_ADD); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== V_ZERO)
            begin errors++; $display("FAIL midrst_async_abort: got %b expected %b", outs(), V_ZERO); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (outs() !== V_FETCH)
            begin errors++; $display("FAIL midrst_restart: got %b expected %b", outs(), V_FETCH); end
    endtask

    task automatic test_trap(input logic [6:0] op, input logic [2:0] f3, input string name);
        set_instr(op, f3, 1'b0);
        set_flags(6'b111111);
        tick();
        checks++;
        if (outs() !== V_ZERO)
            begin errors++; $display("FAIL %s_decode: got %b expected %b", name, outs(), V_ZERO); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (outs() !== V_TRAP)
                begin errors++; $display("FAIL %s_trap cyc%0d: got %b expected %b", name, i, outs(), V_TRAP); end
            set_instr(7'b0110011, 3'b000, 1'b0);
            bus.dm_ready = 1'b1;
        end
        bus.dm_ready = 1'b0;
        set_flags(6'b000000);
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== V_ZERO)
            begin errors++; $display("FAIL %s_rst_clears: got %b expected %b", name, outs(), V_ZERO); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (outs() !== V_FETCH)
            begin errors++; $display("FAIL %s_recover: got %b expected %b", name, outs(), V_FETCH); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_ops();
        test_load_stall();
        test_store_stall();
        test_branch();
        test_jumps();
        test_mid_reset();
        test_trap(7'b1100011, 3'b010, "br_f3_010");
        test_trap(7'b0110111, 3'b000, "lui");
        test_trap(7'b1111111, 3'b000, "unknown_op");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
